// File: rtl/cpu_bus_responder.sv
// Byte-wide bus target for the CPU: scratch RAM, GPIO port and a prescaled 16-bit
// timer with compare/overflow interrupt. Reads are combinational; writes land on the clock edge.
module cpu_bus_responder #(
  parameter int RAM_DEPTH   = 224,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] address,
  input  logic       write_enable,
  input  logic [7:0] write_data,
  output logic [7:0] read_data,
  output logic [7:0] gpio_out,
  input  logic [7:0] gpio_in,
  output logic       timer_irq
);

  localparam logic [8:0] RAM_END      = 9'(RAM_DEPTH);
  localparam logic [7:0] A_GPIO_OUT   = 8'hF0;
  localparam logic [7:0] A_GPIO_IN    = 8'hF1;
  localparam logic [7:0] A_CTRL       = 8'hF2;
  localparam logic [7:0] A_STATUS     = 8'hF3;
  localparam logic [7:0] A_COUNT_LO   = 8'hF4;
  localparam logic [7:0] A_COUNT_HI   = 8'hF5;
  localparam logic [7:0] A_CAPTURE    = 8'hF6;
  localparam logic [7:0] A_COMPARE_LO = 8'hF7;
  localparam logic [7:0] A_COMPARE_HI = 8'hF8;

  logic [7:0]  ram [RAM_DEPTH];
  logic [7:0]  gpio_out_r;
  logic [7:0]  sync_q [SYNC_STAGES];
  logic        ctrl_en, ctrl_com, ctrl_ie;
  logic [3:0]  ctrl_p;
  logic        st_match, st_ovf;
  logic [15:0] count, snap, compare, prescaler;

  logic        ram_hit;
  logic        tick, set_match, set_ovf;
  logic        wr_status;
  logic [15:0] pre_mask, count_ticked, count_next;

  assign ram_hit   = ({1'b0, address} < RAM_END);
  assign wr_status = write_enable && (address == A_STATUS);

  // Tick when the low p prescaler bits are all ones; p = 0 gives an empty mask.
  always_comb begin
    pre_mask     = ~(16'hFFFF << ctrl_p);
    tick         = ctrl_en && ((prescaler & pre_mask) == pre_mask);
    set_match    = tick && (count == compare);
    set_ovf      = tick && !set_match && (count == 16'hFFFF);
    count_ticked = count + 16'd1;
    if (set_match && ctrl_com) count_ticked = 16'h0000;
    count_next = tick ? count_ticked : count;
    // A CPU byte load overrides the tick; the untouched byte keeps its pre-tick value.
    if (write_enable && address == A_COUNT_LO)      count_next = {count[15:8], write_data};
    else if (write_enable && address == A_COUNT_HI) count_next = {write_data, count[7:0]};
  end

  always_ff @(posedge clock) begin
    if (write_enable && ram_hit) ram[address] <= write_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 8'h00;
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gpio_out_r <= 8'h00;
      ctrl_en    <= 1'b0;
      ctrl_com   <= 1'b0;
      ctrl_ie    <= 1'b0;
      ctrl_p     <= 4'h0;
      st_match   <= 1'b0;
      st_ovf     <= 1'b0;
      count      <= 16'h0000;
      snap       <= 16'h0000;
      compare    <= 16'h0000;
      prescaler  <= 16'h0000;
    end else begin
      prescaler <= ctrl_en ? prescaler + 16'd1 : 16'h0000;
      count     <= count_next;
      // Set events take priority over a simultaneous write-1-to-clear.
      st_match  <= set_match | (st_match & ~(wr_status & write_data[0]));
      st_ovf    <= set_ovf   | (st_ovf   & ~(wr_status & write_data[1]));
      if (write_enable) begin
        case (address)
          A_GPIO_OUT:   gpio_out_r <= write_data;
          A_CTRL: begin
            ctrl_en  <= write_data[0];
            ctrl_com <= write_data[1];
            ctrl_ie  <= write_data[2];
            ctrl_p   <= write_data[7:4];
          end
          A_CAPTURE:    snap <= count;
          A_COMPARE_LO: compare[7:0]  <= write_data;
          A_COMPARE_HI: compare[15:8] <= write_data;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    read_data = 8'h00;
    if (ram_hit) begin
      read_data = ram[address];
    end else begin
      case (address)
        A_GPIO_OUT:   read_data = gpio_out_r;
        A_GPIO_IN:    read_data = sync_q[SYNC_STAGES-1];
        A_CTRL:       read_data = {ctrl_p, 1'b0, ctrl_ie, ctrl_com, ctrl_en};
        A_STATUS:     read_data = {6'd0, st_ovf, st_match};
        A_COUNT_LO:   read_data = snap[7:0];
        A_COUNT_HI:   read_data = snap[15:8];
        A_COMPARE_LO: read_data = compare[7:0];
        A_COMPARE_HI: read_data = compare[15:8];
        default:      read_data = 8'h00;
      endcase
    end
  end

  assign gpio_out  = gpio_out_r;
  assign timer_irq = ctrl_ie & (st_match | st_ovf);

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Self-checking bench for cpu_bus_responder: directed scenarios plus a randomized
// bus-traffic phase scored against a cycle-level behavioural model of the register map.
module tb_cpu_bus_responder;
  localparam int RAM_DEPTH   = 224;
  localparam int SYNC_STAGES = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] address = 8'h00;
  logic       write_enable = 1'b0;
  logic [7:0] write_data = 8'h00;
  logic [7:0] gpio_in = 8'h00;
  logic [7:0] read_data;
  logic [7:0] gpio_out;
  logic       timer_irq;

  int n_checks = 0;
  int n_fails  = 0;

  always #10 clock = ~clock;

  cpu_bus_responder #(.RAM_DEPTH(RAM_DEPTH), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clock(clock), .reset(reset), .address(address), .write_enable(write_enable),
    .write_data(write_data), .read_data(read_data), .gpio_out(gpio_out),
    .gpio_in(gpio_in), .timer_irq(timer_irq)
  );

  // Reference model state
  logic [7:0] m_ram [256];
  bit         m_valid [256];
  logic [7:0] m_gpio;
  logic [7:0] m_sync [SYNC_STAGES];
  bit         m_en, m_com, m_ie, m_match, m_ovf;
  int         m_p, m_count, m_snap, m_cmp, m_pre;

  task automatic model_reset();
    m_gpio = 8'h00;
    for (int i = 0; i < SYNC_STAGES; i++) m_sync[i] = 8'h00;
    m_en = 0; m_com = 0; m_ie = 0; m_match = 0; m_ovf = 0;
    m_p = 0; m_count = 0; m_snap = 0; m_cmp = 0; m_pre = 0;
  endtask

  function automatic logic [7:0] mread(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h00;
    if (int'(a) < RAM_DEPTH) r = m_ram[a];
    else case (a)
      8'hF0: r = m_gpio;
      8'hF1: r = m_sync[SYNC_STAGES-1];
      8'hF2: r = {4'(m_p), 1'b0, m_ie, m_com, m_en};
      8'hF3: r = {6'd0, m_ovf, m_match};
      8'hF4: r = 8'(m_snap % 256);
      8'hF5: r = 8'(m_snap / 256);
      8'hF7: r = 8'(m_cmp % 256);
      8'hF8: r = 8'(m_cmp / 256);
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic bit mirq();
    return m_ie && (m_match || m_ovf);
  endfunction

  task automatic model_edge(input bit we, input logic [7:0] a, input logic [7:0] d,
                            input logic [7:0] gin);
    int period, n_count;
    bit sm, so, tk;
    period  = 1 << m_p;
    tk      = m_en && ((m_pre % period) == period - 1);
    n_count = m_count; sm = 0; so = 0;
    if (tk) begin
      if (m_count == m_cmp) begin
        sm = 1;
        n_count = m_com ? 0 : (m_count + 1) % 65536;
      end else if (m_count == 65535) begin
        so = 1;
        n_count = 0;
      end else n_count = m_count + 1;
    end
    m_pre = m_en ? (m_pre + 1) % 65536 : 0;
    for (int i = SYNC_STAGES - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = gin;
    if (we) begin
      if (int'(a) < RAM_DEPTH) begin
        m_ram[a] = d; m_valid[a] = 1;
      end else case (a)
        8'hF0: m_gpio = d;
        8'hF2: begin m_en = d[0]; m_com = d[1]; m_ie = d[2]; m_p = int'(d[7:4]); end
        8'hF3: begin if (d[0]) m_match = 0; if (d[1]) m_ovf = 0; end
        8'hF4: n_count = (m_count & 'hFF00) | int'(d);
        8'hF5: n_count = (m_count & 'h00FF) | (int'(d) << 8);
        8'hF6: m_snap = m_count;
        8'hF7: m_cmp = (m_cmp & 'hFF00) | int'(d);
        8'hF8: m_cmp = (m_cmp & 'h00FF) | (int'(d) << 8);
        default: ;
      endcase
    end
    if (sm) m_match = 1;
    if (so) m_ovf = 1;
    m_count = n_count;
  endtask

  // One bus cycle: drive, take the edge, advance the model, leave at edge+1.
  task automatic cycle(input bit we, input logic [7:0] a, input logic [7:0] d);
    address = a; write_enable = we; write_data = d;
    @(posedge clock);
    model_edge(we, a, d, gpio_in);
    #1;
    write_enable = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    cycle(1'b1, a, d);
  endtask

  task automatic idle();
    cycle(1'b0, 8'hF3, 8'h00);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (gpio_out !== 8'h00) begin n_fails++; $display("FAIL reset_gpio_out got %02h want 00", gpio_out); end
    n_checks++;
    if (timer_irq !== 1'b0) begin n_fails++; $display("FAIL reset_irq got %b want 0", timer_irq); end
    for (int a = 8'hF0; a <= 8'hFF; a++) begin
      address = 8'(a);
      #1;
      n_checks++;
      if (read_data !== 8'h00) begin
        n_fails++; $display("FAIL reset_reg_%02h got %02h want 00", a, read_data);
      end
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_ram();
    logic [7:0] top;
    top = 8'(RAM_DEPTH - 1);
    wr(8'h00, 8'hA5);
    wr(top, 8'h5A);
    address = 8'h00; #1; n_checks++;
    if (read_data !== 8'hA5) begin n_fails++; $display("FAIL ram_first got %02h want a5", read_data); end
    address = top; #1; n_checks++;
    if (read_data !== 8'h5A) begin n_fails++; $display("FAIL ram_last got %02h want 5a", read_data); end
    address = 8'hE5; #1; n_checks++;
    if (read_data !== 8'h00) begin n_fails++; $display("FAIL ram_hole got %02h want 00", read_data); end
    wr(8'hFA, 8'h77);
    address = 8'hFA; #1; n_checks++;
    if (read_data !== 8'h00) begin n_fails++; $display("FAIL unmapped_fa got %02h want 00", read_data); end
    wr(8'hE5, 8'h99);
    address = 8'hE5; #1; n_checks++;
    if (read_data !== 8'h00) begin n_fails++; $display("FAIL hole_write got %02h want 00", read_data); end
  endtask

  task automatic test_gpio();
    logic [7:0] want;
    wr(8'hF0, 8'h3C);
    n_checks++;
    if (gpio_out !== 8'h3C) begin n_fails++; $display("FAIL gpio_out got %02h want 3c", gpio_out); end
    gpio_in = 8'h81;
    for (int k = 1; k <= SYNC_STAGES; k++) begin
      cycle(1'b0, 8'hF1, 8'h00);
      address = 8'hF1; #1;
      want = (k == SYNC_STAGES) ? 8'h81 : 8'h00;
      n_checks++;
      if (read_data !== want) begin
        n_fails++; $display("FAIL gpio_in_edge%0d got %02h want %02h", k, read_data, want);
      end
    end
  endtask

  task automatic test_timer_compare();
    logic [7:0] lo, hi;
    wr(8'hF2, 8'h00); wr(8'hF4, 8'h00); wr(8'hF5, 8'h00);
    wr(8'hF7, 8'h05); wr(8'hF8, 8'h00); wr(8'hF3, 8'h03);
    wr(8'hF2, 8'h07);
    repeat (5) idle();
    address = 8'hF3; #1; n_checks++;
    if (read_data !== 8'h00) begin n_fails++; $display("FAIL cmp_before_match got %02h want 00", read_data); end
    idle();
    address = 8'hF3; #1; n_checks++;
    if (read_data !== 8'h01) begin n_fails++; $display("FAIL cmp_match got %02h want 01", read_data); end
    n_checks++;
    if (timer_irq !== 1'b1) begin n_fails++; $display("FAIL cmp_irq got %b want 1", timer_irq); end
    wr(8'hF6, 8'h00);
    address = 8'hF4; #1; lo = read_data;
    address = 8'hF5; #1; hi = read_data;
    n_checks++;
    if ({hi, lo} !== 16'h0000) begin n_fails++; $display("FAIL cmp_cleared_count got %04h want 0000", {hi, lo}); end
    wr(8'hF3, 8'h01);
    n_checks++;
    if (timer_irq !== 1'b0) begin n_fails++; $display("FAIL cmp_irq_clear got %b want 0", timer_irq); end
    wr(8'hF2, 8'h00);
  endtask

  task automatic test_overflow_prescale();
    logic [7:0]  lo, hi;
    logic [15:0] want;
    wr(8'hF3, 8'h03); wr(8'hF4, 8'hFE); wr(8'hF5, 8'hFF);
    wr(8'hF7, 8'h00); wr(8'hF8, 8'h00);
    wr(8'hF2, 8'h21);
    for (int k = 1; k <= 9; k++) begin
      wr(8'hF6, 8'h00);
      address = 8'hF4; #1; lo = read_data;
      address = 8'hF5; #1; hi = read_data;
      want = (k <= 4) ? 16'hFFFE : (k <= 8) ? 16'hFFFF : 16'h0000;
      n_checks++;
      if ({hi, lo} !== want) begin
        n_fails++; $display("FAIL presc_capture%0d got %04h want %04h", k, {hi, lo}, want);
      end
    end
    address = 8'hF3; #1; n_checks++;
    if (read_data !== 8'h02) begin n_fails++; $display("FAIL ovf_status got %02h want 02", read_data); end
    n_checks++;
    if (timer_irq !== 1'b0) begin n_fails++; $display("FAIL ovf_irq_masked got %b want 0", timer_irq); end
    wr(8'hF2, 8'h00);
  endtask

  task automatic test_collisions();
    logic [7:0] lo, hi;
    wr(8'hF3, 8'h03); wr(8'hF4, 8'h00); wr(8'hF5, 8'h00);
    wr(8'hF7, 8'h03); wr(8'hF8, 8'h00);
    wr(8'hF2, 8'h03);
    repeat (3) idle();
    wr(8'hF3, 8'h03);
    address = 8'hF3; #1; n_checks++;
    if (read_data !== 8'h01) begin n_fails++; $display("FAIL clr_vs_set got %02h want 01", read_data); end
    wr(8'hF4, 8'h10);
    wr(8'hF6, 8'h00);
    address = 8'hF4; #1; lo = read_data;
    address = 8'hF5; #1; hi = read_data;
    n_checks++;
    if ({hi, lo} !== 16'h0010) begin n_fails++; $display("FAIL load_vs_tick got %04h want 0010", {hi, lo}); end
    wr(8'hF2, 8'h07);
    n_checks++;
    if (timer_irq !== 1'b1) begin n_fails++; $display("FAIL coll_irq got %b want 1", timer_irq); end
  endtask

  task automatic test_async_reset();
    logic [7:0] lo, hi;
    wr(8'h10, 8'hC3);
    wr(8'hF0, 8'h55);
    n_checks++;
    if (gpio_out !== 8'h55) begin n_fails++; $display("FAIL pre_reset_gpio got %02h want 55", gpio_out); end
    #3;
    reset = 1'b1;
    #1;
    n_checks++;
    if (gpio_out !== 8'h00) begin n_fails++; $display("FAIL async_gpio got %02h want 00", gpio_out); end
    n_checks++;
    if (timer_irq !== 1'b0) begin n_fails++; $display("FAIL async_irq got %b want 0", timer_irq); end
    address = 8'hF2; #1; n_checks++;
    if (read_data !== 8'h00) begin n_fails++; $display("FAIL async_ctrl got %02h want 00", read_data); end
    address = 8'hF3; #1; n_checks++;
    if (read_data !== 8'h00) begin n_fails++; $display("FAIL async_status got %02h want 00", read_data); end
    model_reset();
    #2;
    reset = 1'b0;
    wr(8'hF6, 8'h00);
    address = 8'hF4; #1; lo = read_data;
    address = 8'hF5; #1; hi = read_data;
    n_checks++;
    if ({hi, lo} !== 16'h0000) begin n_fails++; $display("FAIL async_count got %04h want 0000", {hi, lo}); end
    address = 8'h10; #1; n_checks++;
    if (read_data !== 8'hC3) begin n_fails++; $display("FAIL ram_retained got %02h want c3", read_data); end
  endtask

  function automatic logic [7:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 3) return 8'($urandom_range(0, RAM_DEPTH - 1));
    if (r == 3) return ($urandom_range(0, 1) != 0) ? 8'($urandom_range(RAM_DEPTH, 239))
                                                  : 8'($urandom_range(249, 255));
    return 8'(32'hF0 + $urandom_range(0, 8));
  endfunction

  task automatic test_random();
    logic [7:0] a, d, ra, want;
    bit         we;
    for (int i = 0; i < 400; i++) begin
      gpio_in = 8'($urandom);
      a  = pick_addr();
      we = ($urandom_range(0, 1) != 0);
      d  = 8'($urandom);
      if (a == 8'hF2) d[7:4] = 4'($urandom_range(0, 2));
      if (a == 8'hF5 || a == 8'hF8) d = 8'($urandom_range(0, 1));
      if (a == 8'hF4 || a == 8'hF7) d = 8'($urandom_range(0, 15));
      cycle(we, a, d);
      n_checks++;
      if (gpio_out !== m_gpio) begin
        n_fails++; $display("FAIL rnd_gpio_out cyc%0d got %02h want %02h", i, gpio_out, m_gpio);
      end
      n_checks++;
      if (timer_irq !== mirq()) begin
        n_fails++; $display("FAIL rnd_irq cyc%0d got %b want %b", i, timer_irq, mirq());
      end
      ra = pick_addr();
      if (int'(ra) < RAM_DEPTH && !m_valid[ra]) ra = 8'hF3;
      address = ra; #1;
      want = mread(ra);
      n_checks++;
      if (read_data !== want) begin
        n_fails++; $display("FAIL rnd_read cyc%0d addr %02h got %02h want %02h", i, ra, read_data, want);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_ram();
    test_gpio();
    test_timer_compare();
    test_overflow_prescale();
    test_collisions();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
